// File: rtl/rf_pkg.sv
// Shared types and defaults for the pipelined register file and its scoreboard.
package rf_pkg;
    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    typedef logic [XLEN_DEF-1:0]          word_t;
    typedef logic [$clog2(NREGS_DEF)-1:0] ridx_t;

    localparam ridx_t REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at write-back, flushed
// wholesale; also keeps a registered popcount of the busy vector.
module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iss_en,
    input  logic [AW-1:0]    iss_rd,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             flush,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_cnt
);
    logic [NREGS-1:0] busy_d, busy_q;
    logic [AW:0]      busy_cnt_d, busy_cnt_q;

    always_comb begin
        busy_d = busy_q;
        for (int k = 1; k < NREGS; k++) begin
            if (flush)
                busy_d[k] = 1'b0;
            // Set beats clear: on WAW the newly issued producer owns the register.
            else if (iss_en && iss_rd == AW'(k))
                busy_d[k] = 1'b1;
            else if (wr_en && wr_addr == AW'(k))
                busy_d[k] = 1'b0;
        end
        busy_d[0] = 1'b0;

        busy_cnt_d = '0;
        for (int k = 0; k < NREGS; k++)
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[k]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = busy_cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// Register file with N combinational read ports, one write-back port, x0 = 0,
// and a busy scoreboard. Define RF_BYPASS_EN for same-cycle write-through reads.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_rd,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);
    logic [NREGS-1:0][XLEN-1:0] rf_d, rf_q;
    logic [NREGS-1:0]           busy;

    always_comb begin
        rf_d = rf_q;
        if (wr_en && wr_addr != '0)
            rf_d[wr_addr] = wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rf_q <= '0;
        else
            rf_q <= rf_d;
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .flush    (flush),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rdat;
        logic            rbsy;

        assign ra = rd_addr[i*AW +: AW];

        always_comb begin
            rdat = rf_q[ra];
            rbsy = busy[ra];
`ifdef RF_BYPASS_EN
            if (wr_en && wr_addr == ra) begin
                rdat = wr_data;
                rbsy = 1'b0;
            end
`endif
            if (ra == '0) begin
                rdat = '0;
                rbsy = 1'b0;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = rdat;
        assign rd_busy[i]              = rbsy;
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized
// traffic against an array-based reference model (honours RF_BYPASS_EN).
module tb_reg_file_sb;
    localparam int XLEN = 32, NREGS = 32, NRD = 2, AW = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [XLEN-1:0]   wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_rd;
    logic              flush;
    logic [AW:0]       busy_cnt;

    int checks = 0;
    int failures = 0;

    logic [XLEN-1:0] m_rf [NREGS];
    bit              m_busy [NREGS];

    reg_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    function automatic void model_clear();
        for (int k = 0; k < NREGS; k++) begin
            m_rf[k]   = '0;
            m_busy[k] = 1'b0;
        end
    endfunction

    function automatic int model_cnt();
        int c = 0;
        for (int k = 0; k < NREGS; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    function automatic logic [XLEN-1:0] exp_data(int a);
        if (a == 0) return '0;
`ifdef RF_BYPASS_EN
        if (wr_en && int'(wr_addr) == a) return wr_data;
`endif
        return m_rf[a];
    endfunction

    function automatic bit exp_busy(int a);
        if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
        if (wr_en && int'(wr_addr) == a) return 1'b0;
`endif
        return m_busy[a];
    endfunction

    function automatic logic [XLEN-1:0] port_data(int i);
        return rd_data[i*XLEN +: XLEN];
    endfunction

    task automatic set_idle();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic set_rd(int p0, int p1);
        rd_addr[0 +: AW]  = AW'(p0);
        rd_addr[AW +: AW] = AW'(p1);
    endtask

    // One clock edge: the model consumes the inputs present at the edge,
    // in the order "write-back clears, then issue sets" with flush overriding.
    task automatic cycle();
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (wr_en && wr_addr != 0) m_rf[wr_addr] = wr_data;
            if (flush) begin
                for (int k = 0; k < NREGS; k++) m_busy[k] = 1'b0;
            end else begin
                if (wr_en) m_busy[wr_addr] = 1'b0;
                if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; set_idle(); set_rd(3, 17);
        model_clear();
        #2;
        checks++;
        if (busy_cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", busy_cnt); end
        checks++;
        if (rd_data !== '0 || rd_busy !== '0) begin
            failures++; $display("FAIL reset_read got=%h/%b exp=0/0", rd_data, rd_busy);
        end
        @(negedge clk); rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hDEADBEEF;
        cycle();
        set_idle(); set_rd(7, 0); #1;
        checks++;
        if (port_data(0) !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_x7 got=%h exp=deadbeef", port_data(0)); end
        checks++;
        if (port_data(1) !== 32'h0) begin failures++; $display("FAIL rd_x0 got=%h exp=0", port_data(1)); end
        wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF;
        cycle();
        set_idle(); #1;
        checks++;
        if (port_data(1) !== 32'h0 || rd_busy[1] !== 1'b0) begin
            failures++; $display("FAIL wr_x0_dropped got=%h/%b exp=0/0", port_data(1), rd_busy[1]);
        end
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_rd = 3; cycle();
        checks++;
        if (busy_cnt !== 1) begin failures++; $display("FAIL sb_cnt_iss3 got=%0d exp=1", busy_cnt); end
        iss_rd = 4; cycle();
        checks++;
        if (busy_cnt !== 2) begin failures++; $display("FAIL sb_cnt_iss4 got=%0d exp=2", busy_cnt); end
        set_idle(); set_rd(3, 4); #1;
        checks++;
        if (rd_busy !== 2'b11) begin failures++; $display("FAIL sb_busy34 got=%b exp=11", rd_busy); end
        wr_en = 1'b1; wr_addr = 3; wr_data = 32'h55; cycle();
        set_idle(); #1;
        checks++;
        if (rd_busy !== 2'b10 || busy_cnt !== 1 || port_data(0) !== 32'h55) begin
            failures++; $display("FAIL sb_wb3 got=busy %b cnt %0d data %h exp=busy 10 cnt 1 data 55",
                                 rd_busy, busy_cnt, port_data(0));
        end
    endtask

    task automatic test_same_cycle();
        iss_en = 1'b1; iss_rd = 9; cycle();
        wr_en = 1'b1; wr_addr = 9; wr_data = 32'hAA; cycle();
        set_idle(); set_rd(9, 0); #1;
        checks++;
        if (rd_busy[0] !== 1'b1 || port_data(0) !== 32'hAA || busy_cnt !== 2) begin
            failures++; $display("FAIL waw_set_wins got=busy %b data %h cnt %0d exp=busy 1 data aa cnt 2",
                                 rd_busy[0], port_data(0), busy_cnt);
        end
    endtask

    task automatic test_flush();
        iss_en = 1'b1;
        iss_rd = 1; cycle();
        iss_rd = 2; cycle();
        iss_rd = 10; cycle();
        checks++;
        if (busy_cnt !== int'(model_cnt())) begin failures++; $display("FAIL flush_pre_cnt got=%0d exp=%0d", busy_cnt, model_cnt()); end
        flush = 1'b1; iss_rd = 11; cycle();
        set_idle(); set_rd(11, 10); #1;
        checks++;
        if (busy_cnt !== 0 || rd_busy !== 2'b00) begin
            failures++; $display("FAIL flush_clear got=cnt %0d busy %b exp=cnt 0 busy 00", busy_cnt, rd_busy);
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 6; wr_data = 32'h10; cycle();
        wr_data = 32'h20; set_rd(6, 0); #1;
        checks++;
`ifdef RF_BYPASS_EN
        if (port_data(0) !== 32'h20) begin failures++; $display("FAIL bypass_same got=%h exp=20", port_data(0)); end
`else
        if (port_data(0) !== 32'h10) begin failures++; $display("FAIL nobypass_same got=%h exp=10", port_data(0)); end
`endif
        cycle();
        set_idle(); #1;
        checks++;
        if (port_data(0) !== 32'h20) begin failures++; $display("FAIL bypass_next got=%h exp=20", port_data(0)); end
    endtask

    task automatic test_random();
        int a [NRD];
        for (int n = 0; n < 400; n++) begin
            wr_en   = ($urandom_range(0, 99) < 50);
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = $urandom;
            iss_en  = ($urandom_range(0, 99) < 50);
            iss_rd  = AW'($urandom_range(0, 7));
            flush   = ($urandom_range(0, 99) < 4);
            for (int i = 0; i < NRD; i++) begin
                a[i] = ($urandom_range(0, 3) == 0) ? int'(wr_addr) : int'($urandom_range(0, 7));
                rd_addr[i*AW +: AW] = AW'(a[i]);
            end
            #1;
            for (int i = 0; i < NRD; i++) begin
                checks++;
                if (port_data(i) !== exp_data(a[i]) || rd_busy[i] !== exp_busy(a[i])) begin
                    failures++;
                    $display("FAIL rand_read it=%0d port=%0d addr=%0d got=%h/%b exp=%h/%b",
                             n, i, a[i], port_data(i), rd_busy[i], exp_data(a[i]), exp_busy(a[i]));
                end
            end
            cycle();
            checks++;
            if (busy_cnt !== int'(model_cnt())) begin
                failures++; $display("FAIL rand_cnt it=%0d got=%0d exp=%0d", n, busy_cnt, model_cnt());
            end
        end
        set_idle();
    endtask

    task automatic test_mid_reset();
        wr_en = 1'b1; wr_addr = 5; wr_data = 32'h1234;
        iss_en = 1'b1; iss_rd = 12; cycle();
        set_idle(); set_rd(5, 12); #1;
        checks++;
        if (port_data(0) !== 32'h1234 || busy_cnt === 0) begin
            failures++; $display("FAIL pre_reset got=%h cnt %0d exp=1234 cnt>0", port_data(0), busy_cnt);
        end
        rst_n = 1'b0; #1;
        checks++;
        if (port_data(0) !== 32'h0 || busy_cnt !== 0 || rd_busy !== 2'b00) begin
            failures++; $display("FAIL async_reset got=%h cnt %0d busy %b exp=0 cnt 0 busy 00",
                                 port_data(0), busy_cnt, rd_busy);
        end
        cycle();
        @(negedge clk); rst_n = 1'b1;
        cycle();
    endtask

    initial begin
        rd_addr = '0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_same_cycle();
        test_flush();
        test_bypass();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
